// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for a five-stage pipeline: load-use, taken-branch and data-memory-wait hazards.
// Latency: outputs are combinational (Mealy) from state and current inputs; state and counters update on the next edge.
// Backpressure: mem_req & ~mem_ready freezes every pipeline register; a memory timeout halts the pipe until rst.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs*    source operands of the instruction in ID
//   ex_rd, ex_mem_read            destination and load flag of the instruction in EX
//   ex_branch_taken               branch/jump resolved taken in EX
//   mem_req, mem_ready            MEM-stage data-memory handshake
//   en_*                          write-enables for PC and inter-stage registers
//   flush_ifid, flush_idex        load a NOP into IF/ID or ID/EX (with matching enable)
//   stall_count                   saturating count of cycles with en_pc low
//   timeout_err                   sticky memory-timeout flag
module pipeline_hazard_sequencer #(
    parameter int REG_ADDR_W        = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  en_pc,
    output logic                  en_ifid,
    output logic                  en_idex,
    output logic                  en_exmem,
    output logic                  en_memwb,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [CNT_W-1:0]      stall_count,
    output logic                  timeout_err
);

    // Bubble counter only ever holds LOAD_STALL_CYCLES-1; wait counter holds up to MEM_TIMEOUT.
    localparam int BUB_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam int WT_W  = $clog2(MEM_TIMEOUT + 1);

    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [BUB_W-1:0] BUB_LAST = BUB_W'(1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(MEM_TIMEOUT - 1);
    localparam logic [WT_W-1:0]  WT_FIRST = WT_W'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             r_ret_state;
    logic [BUB_W-1:0]   r_bub_cnt;
    logic [WT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_timeout_err;

    state_t             w_nxt_state;
    state_t             w_nxt_ret_state;
    state_t             w_eval_state;
    logic [BUB_W-1:0]   w_nxt_bub_cnt;
    logic [WT_W-1:0]    w_nxt_wait_cnt;
    logic               w_nxt_timeout_err;
    logic               w_lu_hz;
    logic               w_mem_stall;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_lu_hz = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign w_mem_stall = mem_req && !mem_ready;

    // On the cycle memory completes, MEM_WAIT behaves exactly like the state
    // it interrupted (outputs and transitions). mem_ready is high then, so
    // w_mem_stall is low and the interrupted state proceeds normally; this
    // also lets a resumed LU_STALL consume its bubble on that cycle.
    assign w_eval_state = ((r_state == S_MEM_WAIT) && mem_ready) ? r_ret_state : r_state;

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_ret_state   <= S_RUN;
            r_bub_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_ret_state   <= w_nxt_ret_state;
            r_bub_cnt     <= w_nxt_bub_cnt;
            r_wait_cnt    <= w_nxt_wait_cnt;
            r_timeout_err <= w_nxt_timeout_err;
            if (!en_pc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_ret_state   = r_ret_state;
        w_nxt_bub_cnt     = r_bub_cnt;
        w_nxt_wait_cnt    = r_wait_cnt;
        w_nxt_timeout_err = r_timeout_err;

        case (w_eval_state)
            S_RUN: begin
                w_nxt_state    = S_RUN;
                w_nxt_wait_cnt = '0;
                if (w_mem_stall) begin
                    w_nxt_state     = S_MEM_WAIT;
                    w_nxt_ret_state = S_RUN;
                    w_nxt_wait_cnt  = WT_FIRST;
                end else if (ex_branch_taken) begin
                    w_nxt_state = S_RUN;
                end else if (w_lu_hz && (LOAD_STALL_CYCLES > 1)) begin
                    w_nxt_state   = S_LU_STALL;
                    w_nxt_bub_cnt = BUB_INIT;
                end
            end

            S_LU_STALL: begin
                w_nxt_state    = S_LU_STALL;
                w_nxt_wait_cnt = '0;
                if (w_mem_stall) begin
                    // Bubble count is frozen across the wait and resumed after.
                    w_nxt_state     = S_MEM_WAIT;
                    w_nxt_ret_state = S_LU_STALL;
                    w_nxt_wait_cnt  = WT_FIRST;
                end else if (r_bub_cnt == BUB_LAST) begin
                    w_nxt_state   = S_RUN;
                    w_nxt_bub_cnt = '0;
                end else begin
                    w_nxt_bub_cnt = r_bub_cnt - BUB_W'(1);
                end
            end

            S_MEM_WAIT: begin
                // Only reached here while mem_ready is low.
                if (r_wait_cnt == WT_LAST) begin
                    w_nxt_state       = S_HALT;
                    w_nxt_timeout_err = 1'b1;
                    w_nxt_wait_cnt    = WT_W'(MEM_TIMEOUT);
                end else begin
                    w_nxt_wait_cnt = r_wait_cnt + WT_W'(1);
                end
            end

            S_HALT: begin
                w_nxt_state = S_HALT;
            end

            default: begin
                w_nxt_state = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        en_pc      = 1'b0;
        en_ifid    = 1'b0;
        en_idex    = 1'b0;
        en_exmem   = 1'b0;
        en_memwb   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        if (!rst) begin
            case (w_eval_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        // fully frozen: defaults
                    end else if (ex_branch_taken) begin
                        // Wrong-path instructions in IF/ID and ID/EX are squashed.
                        en_pc      = 1'b1;
                        en_ifid    = 1'b1;
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (w_lu_hz) begin
                        // Hold PC and ID, inject a bubble into EX, let the load advance.
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        flush_idex = 1'b1;
                    end else begin
                        en_pc    = 1'b1;
                        en_ifid  = 1'b1;
                        en_idex  = 1'b1;
                        en_exmem = 1'b1;
                        en_memwb = 1'b1;
                    end
                end

                S_LU_STALL: begin
                    // EX holds a bubble here, so ex_branch_taken cannot be genuine.
                    if (!w_mem_stall) begin
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        flush_idex = 1'b1;
                    end
                end

                default: begin
                    // MEM_WAIT (not ready) and HALT: fully frozen.
                end
            endcase
        end
    end

    assign stall_count = r_stall_cnt;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
module tb_pipeline_hazard_sequencer;

    localparam int RW  = 4;
    localparam int CW  = 5;

    // Enable order: {pc, ifid, idex, exmem, memwb}; flush order: {ifid, idex}
    localparam logic [4:0] EA = 5'b11111;
    localparam logic [4:0] EL = 5'b00111;
    localparam logic [4:0] EZ = 5'b00000;
    localparam logic [1:0] FN = 2'b00;
    localparam logic [1:0] FB = 2'b11;
    localparam logic [1:0] FL = 2'b01;

    logic          clk;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ready;
    logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic          flush_ifid, flush_idex;
    logic [CW-1:0] stall_count;
    logic          timeout_err;

    pipeline_hazard_sequencer #(
        .REG_ADDR_W       (RW),
        .LOAD_STALL_CYCLES(2),
        .MEM_TIMEOUT      (4),
        .CNT_W            (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .en_pc          (en_pc),
        .en_ifid        (en_ifid),
        .en_idex        (en_idex),
        .en_exmem       (en_exmem),
        .en_memwb       (en_memwb),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .stall_count    (stall_count),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [4:0]    en;
        logic [1:0]    fl;
        logic [CW-1:0] cnt;
        logic          terr;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            vec_idx = 0;
    logic [CW-1:0] exp_cnt = '0;

    // Drive one cycle of inputs and queue the response expected in that cycle.
    // The stall-count expectation is the running tally of expected en_pc=0 cycles.
    task automatic vec(input logic r, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic u1, input logic u2, input logic [RW-1:0] erd,
                       input logic mrd, input logic br, input logic mq, input logic my,
                       input logic [4:0] en, input logic [1:0] fl, input logic terr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = erd; ex_mem_read = mrd; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        e.idx  = vec_idx;
        e.en   = en;
        e.fl   = fl;
        e.cnt  = exp_cnt;
        e.terr = terr;
        sb_q.push_back(e);
        vec_idx++;
        if (r) exp_cnt = '0;
        else if (!en[4] && (exp_cnt != '1)) exp_cnt = exp_cnt + CW'(1);
    endtask

    task automatic idle();
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EA, FN, 0);
    endtask

    // Monitor: every cycle presents a response; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({en_pc, en_ifid, en_idex, en_exmem, en_memwb} !== e.en) begin
                    errors++;
                    $display("FAIL vec%0d enables: got %b want %b", e.idx,
                             {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, e.en);
                end
                checks++;
                if ({flush_ifid, flush_idex} !== e.fl) begin
                    errors++;
                    $display("FAIL vec%0d flushes: got %b want %b", e.idx,
                             {flush_ifid, flush_idex}, e.fl);
                end
                checks++;
                if (stall_count !== e.cnt) begin
                    errors++;
                    $display("FAIL vec%0d stall_count: got %0d want %0d", e.idx, stall_count, e.cnt);
                end
                checks++;
                if (timeout_err !== e.terr) begin
                    errors++;
                    $display("FAIL vec%0d timeout_err: got %b want %b", e.idx, timeout_err, e.terr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);

        // Out of reset, idle
        idle(); idle();

        // Load-use on rs2: two bubbles, then run
        vec(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, EL, FL, 0);
        vec(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, EL, FL, 0);
        vec(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, EA, FN, 0);

        // Branch coincident with load-use: branch wins, no stall
        vec(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, EA, FB, 0);
        idle();

        // Load to r0 never stalls; unused matching rs1 never stalls
        vec(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, EA, FN, 0);
        vec(0, 7, 3, 0, 1, 7, 1, 0, 0, 0, EA, FN, 0);

        // Load-use on rs1
        vec(0, 9, 0, 1, 0, 9, 1, 0, 0, 0, EL, FL, 0);
        vec(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, EL, FL, 0);
        vec(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, EA, FN, 0);

        // Memory wait of 3 cycles
        repeat (3) vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EZ, FN, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EA, FN, 0);
        idle();

        // Memory wait arriving during LU_STALL: last bubble resumes afterwards
        vec(0, 0, 4, 0, 1, 4, 1, 0, 0, 0, EL, FL, 0);
        vec(0, 0, 4, 0, 1, 0, 0, 0, 1, 0, EZ, FN, 0);
        vec(0, 0, 4, 0, 1, 0, 0, 0, 1, 0, EZ, FN, 0);
        vec(0, 0, 4, 0, 1, 0, 0, 0, 1, 1, EL, FL, 0);
        vec(0, 0, 4, 0, 1, 0, 0, 0, 0, 0, EA, FN, 0);

        // Memory stall outranks a taken branch; branch applies when memory completes
        vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EZ, FN, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, EA, FB, 0);
        idle();

        // Taken branch is ignored in LU_STALL
        vec(0, 0, 6, 0, 1, 6, 1, 0, 0, 0, EL, FL, 0);
        vec(0, 0, 6, 0, 1, 0, 0, 1, 0, 0, EL, FL, 0);
        vec(0, 0, 6, 0, 1, 0, 0, 0, 0, 0, EA, FN, 0);

        // Memory stall outranks load-use; load-use sequence starts on completion
        vec(0, 0, 2, 0, 1, 2, 1, 0, 1, 0, EZ, FN, 0);
        vec(0, 0, 2, 0, 1, 2, 1, 0, 1, 1, EL, FL, 0);
        vec(0, 0, 2, 0, 1, 0, 0, 0, 0, 0, EL, FL, 0);
        idle();

        // Timeout after 4 not-ready cycles; HALT ignores mem_ready; count saturates
        repeat (4) vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EZ, FN, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EZ, FN, 1);
        repeat (20) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EZ, FN, 1);

        // Reset out of HALT
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EZ, FN, 1);
        idle();

        // Reset in the middle of a load-use stall
        vec(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, EL, FL, 0);
        vec(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, EZ, FN, 0);
        vec(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, EA, FN, 0);

        // Reset in the middle of a memory wait
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EZ, FN, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, EZ, FN, 0);
        idle();
        idle();

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
